// File: rtl/im_sram_arbiter.sv
// Round-robin arbiter sharing one read port of the iM/projM_neg/projM_pos banks among three requesters.
// Each requester owns a slot (IDLE/PEND/FULL) and a response buffer returned over valid/ready.
module im_sram_arbiter #(
   parameter int unsigned HV_DIMENSION = 2048,
   parameter int unsigned ADDR_WIDTH   = 8,
   parameter int unsigned SRAM_LATENCY = 2
) (
   input  logic                      Clk_CI,
   input  logic                      Reset_RI,
   input  logic [2:0]                ReqValid_SI,
   input  logic [3*ADDR_WIDTH-1:0]   ReqAddr_DI,
   output logic [2:0]                ReqReady_SO,
   output logic [2:0]                RspValid_SO,
   input  logic [2:0]                RspReady_SI,
   output logic [3*HV_DIMENSION-1:0] RspIM_DO,
   output logic [3*HV_DIMENSION-1:0] RspNeg_DO,
   output logic [3*HV_DIMENSION-1:0] RspPos_DO,
   output logic                      SramReq_SO,
   output logic [ADDR_WIDTH-1:0]     SramAddr_DO,
   input  logic [HV_DIMENSION-1:0]   SramIM_DI,
   input  logic [HV_DIMENSION-1:0]   SramNeg_DI,
   input  logic [HV_DIMENSION-1:0]   SramPos_DI
);

   localparam int unsigned NUM_REQ    = 3;
   localparam int unsigned ID_WIDTH   = 2;
   localparam int unsigned TAG_STAGES = SRAM_LATENCY + 1;

   typedef enum logic [1:0] {
      SLOT_IDLE = 2'd0,
      SLOT_PEND = 2'd1,
      SLOT_FULL = 2'd2
   } slot_e;

   slot_e                   slot_q [NUM_REQ];
   slot_e                   slot_d [NUM_REQ];
   logic [ID_WIDTH-1:0]     ptr_q, ptr_d;
   logic [NUM_REQ-1:0]      eligible;
   logic [NUM_REQ-1:0]      grant;
   logic [ID_WIDTH-1:0]     grant_id;
   logic [ADDR_WIDTH-1:0]   grant_addr;
   logic [TAG_STAGES-1:0]   tag_vld_q;
   logic [ID_WIDTH-1:0]     tag_id_q [TAG_STAGES];
   logic                    tag_exit_vld;
   logic [ID_WIDTH-1:0]     tag_exit_id;
   logic [HV_DIMENSION-1:0] im_q  [NUM_REQ];
   logic [HV_DIMENSION-1:0] neg_q [NUM_REQ];
   logic [HV_DIMENSION-1:0] pos_q [NUM_REQ];

   // (base + offset) mod 3 for the rotating priority order
   function automatic logic [ID_WIDTH-1:0] rr_index(input logic [ID_WIDTH-1:0] base,
                                                     input int unsigned offset);
      int unsigned sum;
      sum = 32'(base) + offset;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return ID_WIDTH'(sum);
   endfunction

   assign tag_exit_vld = tag_vld_q[TAG_STAGES-1];
   assign tag_exit_id  = tag_id_q[TAG_STAGES-1];
   assign ReqReady_SO  = grant;
   assign grant_addr   = ReqAddr_DI[32'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];

   // Eligibility uses the registered slot state, so a consumed slot is re-grantable one cycle later
   always_comb begin
      eligible = '0;
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
         eligible[r] = ReqValid_SI[r] && (slot_q[r] == SLOT_IDLE);
      end
   end

   // First eligible requester at or after the pointer wins
   always_comb begin
      grant    = '0;
      grant_id = '0;
      ptr_d    = ptr_q;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if ((grant == '0) && eligible[rr_index(ptr_q, k)]) begin
            grant[rr_index(ptr_q, k)] = 1'b1;
            grant_id                  = rr_index(ptr_q, k);
            ptr_d                     = rr_index(ptr_q, k + 1);
         end
      end
   end

   // Slot next-state and response-valid decode
   always_comb begin
      RspValid_SO = '0;
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
         slot_d[r] = slot_q[r];
         case (slot_q[r])
            SLOT_IDLE: if (grant[r]) slot_d[r] = SLOT_PEND;
            SLOT_PEND: if (tag_exit_vld && (tag_exit_id == ID_WIDTH'(r))) slot_d[r] = SLOT_FULL;
            SLOT_FULL: if (RspReady_SI[r]) slot_d[r] = SLOT_IDLE;
            default:   slot_d[r] = SLOT_IDLE;
         endcase
         RspValid_SO[r] = (slot_q[r] == SLOT_FULL);
      end
   end

   always_ff @(posedge Clk_CI) begin
      if (Reset_RI) begin
         ptr_q       <= '0;
         tag_vld_q   <= '0;
         SramReq_SO  <= 1'b0;
         SramAddr_DO <= '0;
         for (int unsigned i = 0; i < TAG_STAGES; i++) tag_id_q[i] <= '0;
         for (int unsigned r = 0; r < NUM_REQ; r++) begin
            slot_q[r] <= SLOT_IDLE;
            im_q[r]   <= '0;
            neg_q[r]  <= '0;
            pos_q[r]  <= '0;
         end
      end else begin
         ptr_q        <= ptr_d;
         SramReq_SO   <= |grant;
         if (|grant) SramAddr_DO <= grant_addr;
         tag_vld_q[0] <= |grant;
         tag_id_q[0]  <= grant_id;
         for (int unsigned i = 1; i < TAG_STAGES; i++) begin
            tag_vld_q[i] <= tag_vld_q[i-1];
            tag_id_q[i]  <= tag_id_q[i-1];
         end
         // The slot is PEND while its tag is in flight, so the buffer is always free here
         for (int unsigned r = 0; r < NUM_REQ; r++) begin
            slot_q[r] <= slot_d[r];
            if (tag_exit_vld && (tag_exit_id == ID_WIDTH'(r))) begin
               im_q[r]  <= SramIM_DI;
               neg_q[r] <= SramNeg_DI;
               pos_q[r] <= SramPos_DI;
            end
         end
      end
   end

   for (genvar r = 0; r < NUM_REQ; r++) begin : g_rsp
      assign RspIM_DO [r*HV_DIMENSION +: HV_DIMENSION] = im_q[r];
      assign RspNeg_DO[r*HV_DIMENSION +: HV_DIMENSION] = neg_q[r];
      assign RspPos_DO[r*HV_DIMENSION +: HV_DIMENSION] = pos_q[r];
   end

endmodule

// File: tb/tb_im_sram_arbiter.sv
// Bench for im_sram_arbiter: directed request vectors with expected grants, plus a scoreboard
// monitor that checks response timing, data and stability against a fixed-latency SRAM model.
module tb_im_sram_arbiter;

   localparam int unsigned HV  = 64;
   localparam int unsigned AW  = 8;
   localparam int unsigned LAT = 2;

   typedef struct {
      logic [AW-1:0] addr;
      int            due;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [2:0]        req_valid;
   logic [3*AW-1:0]   req_addr;
   logic [2:0]        req_ready;
   logic [2:0]        rsp_valid;
   logic [2:0]        rsp_ready;
   logic [3*HV-1:0]   rsp_im, rsp_neg, rsp_pos;
   logic              sram_req;
   logic [AW-1:0]     sram_addr;
   logic [HV-1:0]     sram_im, sram_neg, sram_pos;

   logic [AW-1:0]     sa_pipe [LAT];
   logic              sv_pipe [LAT];
   logic [AW-1:0]     addr    [3];
   exp_t              exp_q   [3][$];
   logic [3*HV-1:0]   held    [3];
   logic [2:0]        prev_v = '0;
   logic              exp_sreq = 1'b0;
   logic [AW-1:0]     exp_saddr = '0;
   int                cyc = 0;
   int                n_checks = 0;
   int                n_pass = 0;

   im_sram_arbiter #(.HV_DIMENSION(HV), .ADDR_WIDTH(AW), .SRAM_LATENCY(LAT)) dut (
      .Clk_CI(clk), .Reset_RI(rst),
      .ReqValid_SI(req_valid), .ReqAddr_DI(req_addr), .ReqReady_SO(req_ready),
      .RspValid_SO(rsp_valid), .RspReady_SI(rsp_ready),
      .RspIM_DO(rsp_im), .RspNeg_DO(rsp_neg), .RspPos_DO(rsp_pos),
      .SramReq_SO(sram_req), .SramAddr_DO(sram_addr),
      .SramIM_DI(sram_im), .SramNeg_DI(sram_neg), .SramPos_DI(sram_pos)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [HV-1:0] im_word(input logic [AW-1:0] a);
      return {32'hA1A1_0000 | 32'(a), 32'(a) ^ 32'h5555_5555};
   endfunction
   function automatic logic [HV-1:0] neg_word(input logic [AW-1:0] a);
      return {32'hB2B2_0000 | 32'(a), ~32'(a)};
   endfunction
   function automatic logic [HV-1:0] pos_word(input logic [AW-1:0] a);
      return {32'hC3C3_0000 | 32'(a), 32'(a) * 32'd3};
   endfunction

   // Fixed-latency SRAM: data for a strobe seen in cycle c appears in cycle c+LAT
   always @(posedge clk) begin
      sv_pipe[0] <= sram_req;
      sa_pipe[0] <= sram_addr;
      for (int i = 1; i < LAT; i++) begin
         sv_pipe[i] <= sv_pipe[i-1];
         sa_pipe[i] <= sa_pipe[i-1];
      end
   end
   assign sram_im  = (sv_pipe[LAT-1] === 1'b1) ? im_word(sa_pipe[LAT-1])  : 64'hDEAD_BEEF_DEAD_BEEF;
   assign sram_neg = (sv_pipe[LAT-1] === 1'b1) ? neg_word(sa_pipe[LAT-1]) : 64'hDEAD_BEEF_DEAD_BEEF;
   assign sram_pos = (sv_pipe[LAT-1] === 1'b1) ? pos_word(sa_pipe[LAT-1]) : 64'hDEAD_BEEF_DEAD_BEEF;

   task automatic chk(input bit ok, input string name, input logic [255:0] act, input logic [255:0] expv);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, expv);
   endtask

   // Monitor: pops the expected entry when a response appears, then checks it stays stable
   always @(negedge clk) begin
      if (rst) begin
         prev_v = '0;
      end else begin
         for (int r = 0; r < 3; r++) begin
            logic [3*HV-1:0] got;
            got = {rsp_im[r*HV +: HV], rsp_neg[r*HV +: HV], rsp_pos[r*HV +: HV]};
            if (rsp_valid[r] && !prev_v[r]) begin
               if (exp_q[r].size() == 0) begin
                  chk(1'b0, $sformatf("unexpected_rsp_r%0d", r), 256'(got), 256'd0);
               end else begin
                  exp_t e;
                  logic [3*HV-1:0] want;
                  e = exp_q[r].pop_front();
                  want = {im_word(e.addr), neg_word(e.addr), pos_word(e.addr)};
                  chk(cyc == e.due, $sformatf("rsp_latency_r%0d", r), 256'(cyc), 256'(e.due));
                  chk(got == want, $sformatf("rsp_data_r%0d", r), 256'(got), 256'(want));
                  held[r] = got;
               end
            end else if (rsp_valid[r] && prev_v[r]) begin
               chk(got == held[r], $sformatf("rsp_stable_r%0d", r), 256'(got), 256'(held[r]));
            end
            prev_v[r] = rsp_valid[r];
         end
      end
   end

   // One cycle of stimulus; eg is the hand-computed grant for this cycle
   task automatic step(input logic [2:0] rv, input logic [2:0] rr, input logic [2:0] eg);
      req_valid = rv;
      rsp_ready = rr;
      req_addr  = {addr[2], addr[1], addr[0]};
      @(negedge clk);
      chk(sram_req == exp_sreq, "sram_req", 256'(sram_req), 256'(exp_sreq));
      chk(sram_addr == exp_saddr, "sram_addr", 256'(sram_addr), 256'(exp_saddr));
      chk(req_ready == eg, "grant", 256'(req_ready), 256'(eg));
      exp_sreq = 1'b0;
      for (int r = 0; r < 3; r++) begin
         if (eg[r]) begin
            exp_t e;
            e.addr = addr[r];
            e.due  = cyc + LAT + 2;
            exp_q[r].push_back(e);
            exp_sreq  = 1'b1;
            exp_saddr = addr[r];
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(3'b000, 3'b111, 3'b000);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      rsp_ready = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int r = 0; r < 3; r++) exp_q[r].delete();
      exp_sreq  = 1'b0;
      exp_saddr = '0;
      @(negedge clk);
      chk(rsp_valid == 3'b000, "reset_rsp_valid", 256'(rsp_valid), 256'd0);
      chk(sram_req == 1'b0, "reset_sram_req", 256'(sram_req), 256'd0);
      chk(sram_addr == '0, "reset_sram_addr", 256'(sram_addr), 256'd0);
      chk(req_ready == 3'b000, "reset_req_ready", 256'(req_ready), 256'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      req_valid = '0;
      rsp_ready = '0;
      req_addr  = '0;
      addr[0] = '0; addr[1] = '0; addr[2] = '0;
      repeat (3) @(posedge clk);
      #1;
      do_reset();

      // Single request from r0
      addr[0] = 8'd5;
      step(3'b001, 3'b111, 3'b001);
      idle(5);

      // All three request from ptr=0: r0, r1, r2 on consecutive cycles
      do_reset();
      addr[0] = 8'd1; addr[1] = 8'd40; addr[2] = 8'd120;
      step(3'b111, 3'b111, 3'b001);
      step(3'b110, 3'b111, 3'b010);
      step(3'b100, 3'b111, 3'b100);
      idle(5);

      // Fairness r0/r2; first grant to r0 also confirms ptr ended at 0
      addr[0] = 8'd17; addr[2] = 8'd99;
      for (int p = 0; p < 2; p++) begin
         step(3'b101, 3'b111, 3'b001);
         step(3'b101, 3'b111, 3'b100);
         for (int i = 0; i < 3; i++) step(3'b101, 3'b111, 3'b000);
      end
      idle(5);

      // Back-pressure on r1: it stays FULL and is not re-granted; its address change is ignored
      do_reset();
      addr[0] = 8'd10; addr[1] = 8'd66; addr[2] = 8'd200;
      step(3'b111, 3'b101, 3'b001);
      step(3'b111, 3'b101, 3'b010);
      addr[1] = 8'd77;
      step(3'b111, 3'b101, 3'b100);
      step(3'b111, 3'b101, 3'b000);
      step(3'b111, 3'b101, 3'b000);
      for (int p = 0; p < 2; p++) begin
         step(3'b111, 3'b101, 3'b001);
         step(3'b111, 3'b101, 3'b000);
         step(3'b111, 3'b101, 3'b100);
         step(3'b111, 3'b101, 3'b000);
         step(3'b111, 3'b101, 3'b000);
      end
      idle(6);

      // Consume and re-request in the same cycle: grant slips by one cycle
      do_reset();
      addr[0] = 8'd9;
      step(3'b001, 3'b111, 3'b001);
      idle(3);
      step(3'b001, 3'b111, 3'b000);
      step(3'b001, 3'b111, 3'b001);
      idle(5);

      // Reset with three reads in flight; stale data must never surface
      do_reset();
      addr[0] = 8'd200; addr[1] = 8'd3; addr[2] = 8'd255;
      step(3'b111, 3'b111, 3'b001);
      step(3'b110, 3'b111, 3'b010);
      step(3'b100, 3'b111, 3'b100);
      do_reset();
      addr[0] = 8'd33; addr[1] = 8'd34; addr[2] = 8'd35;
      step(3'b111, 3'b111, 3'b001);
      step(3'b110, 3'b111, 3'b010);
      step(3'b100, 3'b111, 3'b100);
      idle(6);

      for (int r = 0; r < 3; r++) begin
         chk(exp_q[r].size() == 0, $sformatf("missing_rsp_r%0d", r), 256'(exp_q[r].size()), 256'd0);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
